// File: rtl/kbd_ps2_pkg.sv
// Shared constants for the PS/2 keyboard event FIFO: scan-code prefixes,
// decoder state encoding and status-byte bit positions.
package kbd_ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_e;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_HEAD_EXT  = 3;
  localparam int ST_HEAD_BRK  = 4;

endpackage

// File: rtl/ps2_keyboard_fifo_ctrl_if.sv
// Receiver byte stream plus PicoBlaze read bus and interrupt of the keyboard FIFO.
interface ps2_keyboard_fifo_ctrl_if;

  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] out_port;
  logic       irq;

  modport master (
    output rx_done_tick, rx_data, port_id, read_strobe,
    input  out_port, irq
  );

  modport slave (
    input  rx_done_tick, rx_data, port_id, read_strobe,
    output out_port, irq
  );

endinterface

// File: rtl/ps2_code_fifo.sv
// Generic synchronous FIFO with head-of-queue output and a one-cycle
// overflow pulse when a push is refused.
module ps2_code_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_fifo_ctrl.sv
// PS/2 scan-code decoder feeding an event FIFO read by PicoBlaze through a
// data port and a status port. Define KBD_BREAK_EN to also queue break events.
module ps2_keyboard_fifo_ctrl
  import kbd_ps2_pkg::*;
#(
  parameter int         DEPTH       = 8,
  parameter logic [7:0] DATA_PORT   = 8'h02,
  parameter logic [7:0] STATUS_PORT = 8'h03
) (
  input logic                     clk,
  input logic                     reset,
  ps2_keyboard_fifo_ctrl_if.slave bus
);

`ifdef KBD_BREAK_EN
  localparam int ENTRY_W = 10;
`else
  localparam int ENTRY_W = 9;
`endif

  kbd_state_e         state_q;
  kbd_state_e         state_d;
  logic               push_req;
  logic               push_ext;
`ifdef KBD_BREAK_EN
  logic               push_brk;
`endif
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic               fifo_ovf;
  logic               ovf_q;
  logic               pop_req;
  logic               status_rd;
  logic [7:0]         status;
  logic [7:0]         data_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Prefix bytes only steer the state; the byte after them carries the code.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    push_ext = 1'b0;
`ifdef KBD_BREAK_EN
    push_brk = 1'b0;
`endif
    if (bus.rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == PS2_EXT)      state_d = EXT;
          else if (bus.rx_data == PS2_BRK) state_d = BRK;
          else                             push_req = 1'b1;
        end
        EXT: begin
          if (bus.rx_data == PS2_BRK)      state_d = EXT_BRK;
          else if (bus.rx_data == PS2_EXT) state_d = EXT;
          else begin
            push_req = 1'b1;
            push_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          state_d = IDLE;
`ifdef KBD_BREAK_EN
          push_req = 1'b1;
          push_brk = 1'b1;
`endif
        end
        EXT_BRK: begin
          state_d = IDLE;
`ifdef KBD_BREAK_EN
          push_req = 1'b1;
          push_ext = 1'b1;
          push_brk = 1'b1;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef KBD_BREAK_EN
  assign push_entry = {push_brk, push_ext, bus.rx_data};
`else
  assign push_entry = {push_ext, bus.rx_data};
`endif

  assign pop_req   = bus.read_strobe && (bus.port_id == DATA_PORT);
  assign status_rd = bus.read_strobe && (bus.port_id == STATUS_PORT);

  ps2_code_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .pop      (pop_req),
    .din      (push_entry),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .overflow (fifo_ovf)
  );

  // Sticky overflow: a new drop on the clearing read's edge takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ovf_q <= 1'b0;
    else if (fifo_ovf)  ovf_q <= 1'b1;
    else if (status_rd) ovf_q <= 1'b0;
  end

  always_comb begin
    status               = 8'h00;
    status[ST_NOT_EMPTY] = !empty;
    status[ST_FULL]      = full;
    status[ST_OVERFLOW]  = ovf_q;
    status[ST_HEAD_EXT]  = !empty && head[8];
`ifdef KBD_BREAK_EN
    status[ST_HEAD_BRK]  = !empty && head[9];
`endif
  end

  assign data_byte = empty ? 8'h00 : head[7:0];

  always_comb begin
    bus.out_port = 8'h00;
    if (bus.port_id == DATA_PORT)        bus.out_port = data_byte;
    else if (bus.port_id == STATUS_PORT) bus.out_port = status;
  end

  assign bus.irq = !empty;

endmodule

// File: tb/tb_ps2_keyboard_fifo_ctrl.sv
// Bench for the PS/2 keyboard event FIFO: vector table, corner sequences and
// randomized traffic against a queue-based event model.
module tb_ps2_keyboard_fifo_ctrl;

  localparam int         DEPTH = 8;
  localparam logic [7:0] DP    = 8'h02;
  localparam logic [7:0] SP    = 8'h03;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_keyboard_fifo_ctrl_if bus ();

  ps2_keyboard_fifo_ctrl #(
    .DEPTH       (DEPTH),
    .DATA_PORT   (DP),
    .STATUS_PORT (SP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: queue of {brk, ext, code} events plus pending-prefix flags.
  logic [9:0] mq[$];
  bit         ext_pend;
  bit         brk_pend;
  bit         m_ovf;

  typedef struct {
    bit         tk;
    logic [7:0] d;
    bit         rd;
    logic [7:0] pid;
    logic [7:0] eo;
    bit         ei;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    logic [9:0] h;
    if (mq.size() == 0) return {5'b0, m_ovf, 2'b00};
    h = mq[0];
    return {3'b0, h[9], h[8], m_ovf, mq.size() == DEPTH, 1'b1};
  endfunction

  function automatic logic [7:0] m_out(input logic [7:0] pid);
    logic [9:0] h;
    if (pid == DP) begin
      if (mq.size() == 0) return 8'h00;
      h = mq[0];
      return h[7:0];
    end
    if (pid == SP) return m_status();
    return 8'h00;
  endfunction

  function automatic void m_event(input bit brk, input bit ext, input logic [7:0] code);
`ifndef KBD_BREAK_EN
    if (brk) return;
`endif
    if (mq.size() >= DEPTH) m_ovf = 1'b1;
    else mq.push_back({brk, ext, code});
  endfunction

  function automatic void m_clock(input bit tk, input logic [7:0] d, input bit rd, input logic [7:0] pid);
    if (rd && pid == DP && mq.size() > 0) void'(mq.pop_front());
    if (rd && pid == SP) m_ovf = 1'b0;
    if (tk) begin
      if (brk_pend) begin
        m_event(1'b1, ext_pend, d);
        brk_pend = 0;
        ext_pend = 0;
      end else if (d == 8'hF0) brk_pend = 1;
      else if (d == 8'hE0) ext_pend = 1;
      else begin
        m_event(1'b0, ext_pend, d);
        ext_pend = 0;
      end
    end
  endfunction

  function automatic void m_reset();
    mq.delete();
    ext_pend = 0;
    brk_pend = 0;
    m_ovf = 0;
  endfunction

  task automatic step(input bit tk, input logic [7:0] d, input bit rd, input logic [7:0] pid,
                      input bit use_exp, input logic [7:0] eo, input bit ei);
    @(negedge clk);
    bus.rx_done_tick = tk;
    bus.rx_data      = d;
    bus.read_strobe  = rd;
    bus.port_id      = pid;
    #1;
    chk("model_out", bus.out_port, m_out(pid));
    chk("model_irq", {7'b0, bus.irq}, {7'b0, mq.size() != 0});
    if (use_exp) begin
      chk("vec_out", bus.out_port, eo);
      chk("vec_irq", {7'b0, bus.irq}, {7'b0, ei});
    end
    @(posedge clk);
    m_clock(tk, d, rd, pid);
  endtask

  task automatic idle_chk(input logic [7:0] pid, input logic [7:0] eo, input bit ei);
    step(1'b0, 8'h00, 1'b0, pid, 1'b1, eo, ei);
  endtask

  task automatic do_reset();
    logic [7:0] pids [4];
    pids = '{DP, SP, 8'h00, 8'hFF};
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.read_strobe  = 1'b0;
    #1 reset = 1'b0;
    m_reset();
    #1;
    chk("rst_irq", {7'b0, bus.irq}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      bus.port_id = pids[i];
      #1 chk("rst_out", bus.out_port, 8'h00);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input bit tk, input logic [7:0] d, input bit rd,
                              input logic [7:0] pid, input logic [7:0] eo, input bit ei);
    vec_t v;
    v.tk = tk; v.d = d; v.rd = rd; v.pid = pid; v.eo = eo; v.ei = ei;
    return v;
  endfunction

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.read_strobe  = 1'b0;
    bus.port_id      = 8'h00;
    m_reset();
    #3;
    do_reset();

`ifndef KBD_BREAK_EN
    // out_port is sampled before the edge that applies each row's inputs.
    vecs.push_back(mk(1, 8'h1C, 0, SP,    8'h00, 0));
    vecs.push_back(mk(1, 8'hF0, 0, SP,    8'h01, 1));
    vecs.push_back(mk(1, 8'h1C, 0, SP,    8'h01, 1));
    vecs.push_back(mk(0, 8'h00, 1, DP,    8'h1C, 1));
    vecs.push_back(mk(0, 8'h00, 0, SP,    8'h00, 0));
    vecs.push_back(mk(1, 8'hE0, 0, SP,    8'h00, 0));
    vecs.push_back(mk(1, 8'h75, 0, SP,    8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 0, SP,    8'h09, 1));
    vecs.push_back(mk(0, 8'h00, 1, DP,    8'h75, 1));
    vecs.push_back(mk(0, 8'h00, 0, SP,    8'h00, 0));
    vecs.push_back(mk(1, 8'hE0, 0, SP,    8'h00, 0));
    vecs.push_back(mk(1, 8'hF0, 0, SP,    8'h00, 0));
    vecs.push_back(mk(1, 8'h75, 0, SP,    8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 0, SP,    8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 1, DP,    8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 0, SP,    8'h00, 0));
    vecs.push_back(mk(1, 8'h2A, 0, 8'h05, 8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 0, 8'h05, 8'h00, 1));
    vecs.push_back(mk(0, 8'h00, 1, DP,    8'h2A, 1));
    vecs.push_back(mk(0, 8'h00, 0, SP,    8'h00, 0));
    foreach (vecs[i])
      step(vecs[i].tk, vecs[i].d, vecs[i].rd, vecs[i].pid, 1'b1, vecs[i].eo, vecs[i].ei);
`else
    step(1'b1, 8'hE0, 1'b0, SP, 1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hF0, 1'b0, SP, 1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h75, 1'b0, SP, 1'b1, 8'h00, 1'b0);
    idle_chk(SP, 8'h19, 1'b1);
    step(1'b0, 8'h00, 1'b1, DP, 1'b1, 8'h75, 1'b1);
    idle_chk(SP, 8'h00, 1'b0);
`endif

    // Overflow: DEPTH+1 make codes with no reads.
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, 8'(8'h15 + i), 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    end
    idle_chk(SP, 8'h07, 1'b1);
    step(1'b0, 8'h00, 1'b1, SP, 1'b1, 8'h07, 1'b1);
    idle_chk(SP, 8'h03, 1'b1);
    // Full FIFO: push coincident with pop keeps it full without overflow.
    step(1'b1, 8'h30, 1'b1, DP, 1'b1, 8'h15, 1'b1);
    idle_chk(SP, 8'h03, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++)
      step(1'b0, 8'h00, 1'b1, DP, 1'b1, 8'(8'h16 + i), 1'b1);
    step(1'b0, 8'h00, 1'b1, DP, 1'b1, 8'h30, 1'b1);
    idle_chk(SP, 8'h00, 1'b0);

    // Reset in the middle of an extended prefix with entries buffered.
    step(1'b1, 8'h1C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h2D, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h3E, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hE0, 1'b0, SP, 1'b1, 8'h01, 1'b1);
    do_reset();
    idle_chk(SP, 8'h00, 1'b0);
    step(1'b1, 8'h1C, 1'b0, SP, 1'b1, 8'h00, 1'b0);
    idle_chk(SP, 8'h01, 1'b1);
    step(1'b0, 8'h00, 1'b1, DP, 1'b1, 8'h1C, 1'b1);
    idle_chk(SP, 8'h00, 1'b0);

    // Randomized traffic against the model.
    begin
      bit last_tk = 0;
      for (int n = 0; n < 4000; n++) begin
        bit         tk;
        bit         rd;
        logic [7:0] d;
        logic [7:0] pid;
        int         sel;
        tk  = !last_tk && ($urandom_range(0, 2) == 0);
        sel = $urandom_range(0, 9);
        d   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
        rd  = ($urandom_range(0, 4) == 0);
        sel = $urandom_range(0, 9);
        pid = (sel < 4) ? DP : (sel < 8) ? SP : 8'($urandom);
        if (!tk) d = 8'h00;
        step(tk, d, rd, pid, 1'b0, 8'h00, 1'b0);
        last_tk = tk;
      end
    end

    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.read_strobe  = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
